// File: rtl/vive_pkg.sv
// Shared definitions for the photodiode sensor pipeline: block layout,
// counter widths and the block-RAM FSM encoding.
package vive_pkg;

  localparam int DATA_W   = 17;
  localparam int TS_W     = 24;
  localparam int BLOCK_W  = 41;
  localparam int DATA_LSB = 0;
  localparam int TS_LSB   = 17;
  localparam int COUNT_W  = 8;
  localparam int IDLE_W   = 17;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FLUSH   = 2'd2
  } block_ram_state_e;

  function automatic logic [BLOCK_W-1:0] pack_block(input logic [TS_W-1:0]   ts,
                                                    input logic [DATA_W-1:0] data);
    logic [BLOCK_W-1:0] blk;
    blk = '0;
    blk[TS_LSB   +: TS_W]   = ts;
    blk[DATA_LSB +: DATA_W] = data;
    return blk;
  endfunction

endpackage

// File: rtl/sensor_block_bram.sv
// Simple dual-port block RAM: one write port, one registered read port with
// enable. Only the read register is reset, so the array can map to iCE40 EBR.
module sensor_block_bram
  import vive_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic               clk_72MHz,
  input  logic               reset,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [BLOCK_W-1:0] i_wr_data,
  input  logic               i_rd_en,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [BLOCK_W-1:0] o_rd_data
);

  logic [BLOCK_W-1:0] r_mem [DEPTH];
  logic [BLOCK_W-1:0] r_rd_data;

  // NOTE: the array has no reset; resetting it would prevent EBR inference.
  always_ff @(posedge clk_72MHz) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_72MHz) begin
    if (reset)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sensor_block_ram.sv
// Per-sensor timestamped block buffer with random-access reads and idle flush.
// Optional macro BLOCK_RAM_DROP_ZERO_EN: ignore writes whose payload is zero.
module sensor_block_ram
  import vive_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int DUMP_TICKS = 90000
) (
  input  logic               clk_72MHz,
  input  logic               reset,
  input  logic [DATA_W-1:0]  lfsr_data,
  input  logic               lfsr_valid,
  input  logic [TS_W-1:0]    sys_ts,
  input  logic [COUNT_W-1:0] block_wanted_number,
  output logic [BLOCK_W-1:0] block_wanted,
  output logic               data_ready,
  output logic [COUNT_W-1:0] avl_blocks_nb,
  output logic               overflow
);

  localparam int                AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(DUMP_TICKS - 1);

  block_ram_state_e r_state, w_state_next;

  logic [COUNT_W-1:0] r_count;
  logic [IDLE_W-1:0]  r_idle;
  logic [COUNT_W-1:0] r_req;
  logic               r_ready;
  logic               r_overflow;

  logic               w_valid;
  logic               w_flush;
  logic               w_wr_en;
  logic               w_drop;
  logic [AW-1:0]      w_wr_addr;
  logic               w_rd_hit;
  logic [AW-1:0]      w_rd_addr;
  logic [BLOCK_W-1:0] w_rd_data;

`ifdef BLOCK_RAM_DROP_ZERO_EN
  assign w_valid = lfsr_valid && (lfsr_data != '0);
`else
  assign w_valid = lfsr_valid;
`endif

  always_ff @(posedge clk_72MHz) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_next;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY:   if (w_valid) w_state_next = ST_FILLING;
      ST_FILLING: if (!w_valid && (r_idle == IDLE_LAST)) w_state_next = ST_FLUSH;
      ST_FLUSH:   w_state_next = w_valid ? ST_FILLING : ST_EMPTY;
      default:    w_state_next = ST_EMPTY;
    endcase
  end

  // A write on the flush cycle lands at address 0 of the freshly emptied buffer.
  always_comb begin
    w_flush   = (r_state == ST_FLUSH);
    w_wr_en   = w_valid && (w_flush || (r_count != DEPTH_C));
    w_drop    = w_valid && !w_flush && (r_count == DEPTH_C);
    w_wr_addr = w_flush ? '0 : r_count[AW-1:0];
    w_rd_hit  = (block_wanted_number == r_req) && (r_req != '0) &&
                (r_req <= r_count) && !w_flush;
    w_rd_addr = AW'(r_req - COUNT_W'(1));
  end

  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      r_count    <= '0;
      r_idle     <= '0;
      r_req      <= '0;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_req   <= block_wanted_number;
      r_ready <= w_rd_hit;
      if (w_flush) begin
        r_count    <= w_valid ? COUNT_W'(1) : '0;
        r_idle     <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr_en) r_count <= r_count + COUNT_W'(1);
        if (w_drop)  r_overflow <= 1'b1;
        if (w_valid)                       r_idle <= '0;
        else if (r_state == ST_FILLING)    r_idle <= r_idle + IDLE_W'(1);
      end
    end
  end

  sensor_block_bram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bram (
    .clk_72MHz (clk_72MHz),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (pack_block(sys_ts, lfsr_data)),
    .i_rd_en   (w_rd_hit),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign block_wanted  = w_rd_data;
  assign data_ready    = r_ready;
  assign avl_blocks_nb = r_count;
  assign overflow      = r_overflow;

endmodule
